// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART receive path: parity modes, FSM encoding and
// the flag positions that sit above the data field in each FIFO entry.
package uart_rx_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Offsets above the data field; an entry is {FE, PE, BE, data}.
    localparam int unsigned BE_BIT = 0;
    localparam int unsigned PE_BIT = 1;
    localparam int unsigned FE_BIT = 2;
    localparam int unsigned FLAG_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } rx_state_e;

    // odd_ones is the XOR of the data bits and the received parity bit.
    function automatic logic parity_err(input logic odd_ones, input int unsigned mode);
        logic err;
        err = 1'b0;
        if (mode == PAR_EVEN) begin
            err = odd_ones;
        end else if (mode == PAR_ODD) begin
            err = ~odd_ones;
        end
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_gen_fifo.sv
// rx_sync_fifo: first-word-fall-through circular buffer with an extra pointer
// MSB for full/empty, and a push that may take the slot freed by a same-cycle pop.
module rx_sync_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned PW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             push_ok_o,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d, level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             pop_c, push_ok_c;

    always_comb begin
        pop_c     = pop_i & ~empty_q;
        push_ok_c = push_i & (~full_q | pop_c);
        wr_d      = wr_q + PW'(push_ok_c);
        rd_d      = rd_q + PW'(pop_c);
        level_d   = wr_d - rd_d;
        empty_d   = (wr_d == rd_d);
        full_d    = (wr_d[AW-1:0] == rd_d[AW-1:0]) && (wr_d[AW] != rd_d[AW]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign push_ok_o = push_ok_c;
    assign rdata_o   = mem_q[rd_q[AW-1:0]];
    assign level_o   = level_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/uart_rx_fifo_gen.sv
// uart_rx_fifo_gen: UART receiver, one line sample per baud_clk edge, frames pushed into rx_sync_fifo.
// Define UART_RX_BREAK_DETECT_EN to add break detection (BE flag and BREAK state).
module uart_rx_fifo_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned FIFO_DEPTH  = 16,
    localparam int unsigned ENTRY_W    = DATA_BITS + FLAG_W,
    localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               baud_clk,
    input  logic               rst,
    input  logic               data_in,
    input  logic               out_ready,
    input  logic               clr_overrun,
    output logic [ENTRY_W-1:0] data_out,
    output logic               out_valid,
    output logic               RxFE,
    output logic               RxFF,
    output logic [LEVEL_W-1:0] level,
    output logic               overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS);

    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 overrun_q, overrun_d;
    logic                 push_c, push_ok_c, brk_c, pe_c;
    logic [ENTRY_W-1:0]   entry_c;

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q;

    // Tracks whether every sample since the start bit has been low.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:             zero_q <= 1'b1;
                ST_DATA, ST_PARITY:  zero_q <= zero_q & ~data_in;
                default:             zero_q <= zero_q;
            endcase
        end
    end

    assign brk_c = zero_q & ~data_in;
`else
    assign brk_c = 1'b0;
`endif

    // The push happens on the edge that samples the stop bit.
    assign push_c = (state_q == ST_STOP);
    assign pe_c   = brk_c ? 1'b0 : parity_err((^shift_q) ^ par_q, PARITY_MODE);

    always_comb begin
        entry_c                     = '0;
        entry_c[DATA_BITS-1:0]      = brk_c ? '0 : shift_q;
        entry_c[DATA_BITS + FE_BIT] = ~data_in;
        entry_c[DATA_BITS + PE_BIT] = pe_c;
        entry_c[DATA_BITS + BE_BIT] = brk_c;
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_in) begin
                        state_q <= ST_DATA;
                        cnt_q   <= '0;
                    end
                end
                ST_DATA: begin
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shift_q <= {data_in, shift_q[DATA_BITS-1:1]};
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_q <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_q   <= data_in;
                    state_q <= ST_STOP;
                end
`ifdef UART_RX_BREAK_DETECT_EN
                ST_STOP:  state_q <= brk_c ? ST_BREAK : ST_IDLE;
                ST_BREAK: if (data_in) state_q <= ST_IDLE;
`else
                ST_STOP:  state_q <= ST_IDLE;
`endif
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // A new overrun beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (push_c && !push_ok_c) overrun_d = 1'b1;
    end

    always_ff @(posedge baud_clk) begin
        if (rst) overrun_q <= 1'b0;
        else     overrun_q <= overrun_d;
    end

    rx_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (baud_clk),
        .rst_i     (rst),
        .push_i    (push_c),
        .wdata_i   (entry_c),
        .pop_i     (out_ready),
        .push_ok_o (push_ok_c),
        .rdata_o   (data_out),
        .level_o   (level),
        .full_o    (RxFF),
        .empty_o   (RxFE)
    );

    assign out_valid = ~RxFE;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo_gen.sv
// Self-checking bench for uart_rx_fifo_gen (8 data bits, even parity, 4-deep FIFO)
// against a queue-based reference model; honours UART_RX_BREAK_DETECT_EN.
module tb_uart_rx_fifo_gen;

    localparam int unsigned DB    = 8;
    localparam int unsigned PM    = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EW    = DB + 3;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          baud_clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_in = 1'b1;
    logic          out_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [EW-1:0] data_out;
    logic          out_valid, RxFE, RxFF, overrun;
    logic [LW-1:0] level;

    uart_rx_fifo_gen #(
        .DATA_BITS   (DB),
        .PARITY_MODE (PM),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .baud_clk    (baud_clk),
        .rst         (rst),
        .data_in     (data_in),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .RxFE        (RxFE),
        .RxFF        (RxFF),
        .level       (level),
        .overrun     (overrun)
    );

    always #5 baud_clk = ~baud_clk;

    typedef struct {
        logic [DB-1:0] d;
        logic          p;
        logic          s;
        logic [EW-1:0] exp;
    } vec_t;

    vec_t          tbl[9];
    logic [EW-1:0] q[$];
    bit            ovr_m;
    int            n_vec = 0;
    int            n_err = 0;
    int            rdy_pct = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 25)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Expected entry from the frame's bits: even parity, FE from the stop bit.
    function automatic logic [EW-1:0] exp_entry(input logic [DB-1:0] d, input logic p, input logic s);
        logic pe;
`ifdef UART_RX_BREAK_DETECT_EN
        if (d == '0 && !p && !s) return {1'b1, 1'b0, 1'b1, {DB{1'b0}}};
`endif
        pe = ((($countones(d) + int'(p)) % 2) == 1);
        return {!s, pe, 1'b0, d};
    endfunction

    function automatic logic rnd_rdy(input bit rnd);
        return rnd ? ($urandom_range(0, 99) < rdy_pct) : 1'b0;
    endfunction

    // One clock: drive inputs, step the model at the edge, check all outputs after it.
    task automatic cyc(input logic line, input logic rdy, input logic clr, input logic rst_v,
                       input logic push, input logic [EW-1:0] ent);
        bit pop, acc;
        data_in     = line;
        out_ready   = rdy;
        clr_overrun = clr;
        rst         = rst_v;
        @(posedge baud_clk);
        if (rst_v) begin
            q.delete();
            ovr_m = 1'b0;
        end else begin
            pop = rdy && (q.size() != 0);
            acc = push && ((q.size() < DEPTH) || pop);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ent);
            if (push && !acc) ovr_m = 1'b1;
            else if (clr)     ovr_m = 1'b0;
        end
        #1;
        chk("RxFE",      32'(RxFE),      32'(q.size() == 0));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("RxFF",      32'(RxFF),      32'(q.size() == DEPTH));
        chk("level",     32'(level),     32'(q.size()));
        chk("overrun",   32'(overrun),   32'(ovr_m));
        if (q.size() != 0) chk("data_out", 32'(data_out), 32'(q[0]));
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, rdy, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s,
                              input bit rnd, input logic rdy_stop, input logic clr_stop);
        cyc(1'b0, rnd_rdy(rnd), 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < DB; i++) cyc(d[i], rnd_rdy(rnd), 1'b0, 1'b0, 1'b0, '0);
        cyc(p, rnd_rdy(rnd), 1'b0, 1'b0, 1'b0, '0);
        cyc(s, rnd ? rnd_rdy(rnd) : rdy_stop, clr_stop, 1'b0, 1'b1, exp_entry(d, p, s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DB-1:0] d;
        logic          p, s;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 11'h0A5};
        tbl[1] = '{8'h07, 1'b0, 1'b1, 11'h207};
        tbl[2] = '{8'h07, 1'b1, 1'b1, 11'h007};
`ifdef UART_RX_BREAK_DETECT_EN
        tbl[3] = '{8'h00, 1'b0, 1'b0, 11'h500};
`else
        tbl[3] = '{8'h00, 1'b0, 1'b0, 11'h400};
`endif
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 11'h0FF};
        tbl[5] = '{8'h80, 1'b0, 1'b0, 11'h680};
        tbl[6] = '{8'h5A, 1'b1, 1'b1, 11'h25A};
        tbl[7] = '{8'hC3, 1'b0, 1'b0, 11'h4C3};
        tbl[8] = '{8'h01, 1'b1, 1'b1, 11'h001};

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(2, 1'b0);

        // Table frames: one entry each, then popped on an idle-high cycle
        for (int i = 0; i < 9; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_entry", i), 32'(data_out), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'd1);
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        end

        // Five back-to-back frames into a 4-deep FIFO: last one dropped
        for (int i = 0; i < 5; i++)
            send_frame(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovr_RxFF", 32'(RxFF), 32'd1);
        chk("ovr_level", 32'(level), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        idle(4, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("ovr_clear", 32'(overrun), 32'd0);

        // Full FIFO with a pop on the stop edge: frame accepted
        for (int i = 0; i < 4; i++)
            send_frame(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("fullpop_level", 32'(level), 32'd4);
        chk("fullpop_ovr", 32'(overrun), 32'd0);
        // Drop and clear on the same edge: set wins
        send_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("setwins_ovr", 32'(overrun), 32'd1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        idle(4, 1'b1);

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        d = 8'hE7;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(d[i], 1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(d[4], 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("midrst_RxFE", 32'(RxFE), 32'd1);
        chk("midrst_level", 32'(level), 32'd0);
        idle(1, 1'b0);
        send_frame(8'h4D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_next", 32'(data_out), 32'h04D);
        idle(2, 1'b1);

        // Line held low for 30 samples, then idle
`ifdef UART_RX_BREAK_DETECT_EN
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("brk_level", 32'(level), 32'd1);
        chk("brk_entry", 32'(data_out), 32'h500);
        idle(2, 1'b0);
`else
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("low30_level", 32'(level), 32'd3);
        chk("low30_head", 32'(data_out), 32'h400);
`endif
        idle(4, 1'b1);
        send_frame(8'h69, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b1);

        // Randomized frames: slow consumer first, then a faster one
        for (int n = 0; n < 60; n++) begin
            rdy_pct = (n < 30) ? 5 : 60;
            d = 8'($urandom_range(0, 255));
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 7) != 0);
            if (d == '0 && !p && !s) s = 1'b1;
            send_frame(d, p, s, 1'b1, 1'b0, 1'($urandom_range(0, 7) == 0));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                cyc(1'b1, rnd_rdy(1'b1), 1'($urandom_range(0, 7) == 0), 1'b0, 1'b0, '0);
        end
        idle(6, 1'b1);
        chk("final_empty", 32'(RxFE), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
